// File: rtl/addr_map_cfg_if.sv
// addr_map_cfg_if: register-bus request/response between a config master and addr_map_cfg
interface addr_map_cfg_if;
  logic        valid;
  logic        ready;
  logic        write;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        error;
  modport master (output valid, write, addr, wdata, wstrb, input ready, rdata, error);
  modport slave (input valid, write, addr, wdata, wstrb, output ready, rdata, error);
endinterface

// File: rtl/addr_map_cfg.sv
// addr_map_cfg: shadow/active address-map table with validated, quiesced atomic commit
module addr_map_cfg #(
  parameter int unsigned NumRules = 4,
  parameter int unsigned NumMstPorts = 4,
  localparam int unsigned PortW = (NumMstPorts > 1) ? $clog2(NumMstPorts) : 1,
  localparam int unsigned KW = (NumRules > 1) ? $clog2(NumRules) : 1,
  parameter logic [NumRules-1:0][159:0] ResetMap = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  addr_map_cfg_if.slave              reg_bus,
  output logic [NumRules-1:0][159:0] addr_map_o,
  output logic                       en_default_mst_port_o,
  output logic [PortW-1:0]           default_mst_port_o,
  output logic                       quiesce_req_o,
  input  logic                       quiesce_ack_i,
  output logic [7:0]                 map_gen_o
);
  typedef enum logic [1:0] {IDLE, CHECK, QUIESCE, APPLY} state_e;
  state_e state_q;
  logic [NumRules-1:0][159:0] sh_q, act_q;
  logic sh_en_q, act_en_q, err_q, locked_q, qreq_q;
  logic [7:0] sh_port_q, act_port_q, gen_q;
  logic [KW-1:0] k_q, ri;
  logic [5:0] err_rule_q;
  logic [11:0] a;
  logic [7:0] boff;
  logic [31:0] rule_rd, wmask;
  logic [159:0] cur;
  logic is_rule, is_ctrl, is_stat, is_dflt, busy, bad, wr_ok, last, rule_bad, dflt_bad;
  logic unused_ok;
  assign a = reg_bus.addr[11:0];
  assign ri = a[5 +: KW];
  assign is_rule = !a[11] && 32'(a[10:5]) < NumRules && a[4:2] <= 3'd4 && a[1:0] == 2'b0;
  assign is_ctrl = a == 12'h800;
  assign is_stat = a == 12'h804;
  assign is_dflt = a == 12'h808;
  // rule word layout inside the packed {idx, start_addr, end_addr} entry
  assign boff = a[4:2] == 3'd0 ? 8'd64 : a[4:2] == 3'd1 ? 8'd96 : a[4:2] == 3'd2 ? 8'd0 :
                a[4:2] == 3'd3 ? 8'd32 : 8'd128;
  assign rule_rd = sh_q[ri][boff +: 32];
  assign wmask = {{8{reg_bus.wstrb[3]}}, {8{reg_bus.wstrb[2]}}, {8{reg_bus.wstrb[1]}}, {8{reg_bus.wstrb[0]}}};
  assign busy = state_q != IDLE;
  assign bad = !(is_rule || is_ctrl || is_stat || is_dflt) ||
               (reg_bus.write && (busy || locked_q || is_stat));
  assign wr_ok = reg_bus.valid && reg_bus.write && !bad;
  assign reg_bus.ready = reg_bus.valid;
  assign reg_bus.error = reg_bus.valid && bad;
  assign reg_bus.rdata = is_rule ? rule_rd :
                         is_stat ? {18'b0, err_rule_q, 5'b0, locked_q, err_q, busy} :
                         is_dflt ? {16'b0, sh_port_q, 7'b0, sh_en_q} : '0;
  assign cur = sh_q[k_q];
  assign last = k_q == KW'(NumRules - 1);
  assign rule_bad = cur[127:64] > cur[63:0] || cur[159:128] >= NumMstPorts;
  assign dflt_bad = sh_en_q && 32'(sh_port_q) >= NumMstPorts;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sh_q <= ResetMap;
      act_q <= ResetMap;
      sh_en_q <= 1'b0;
      sh_port_q <= '0;
      act_en_q <= 1'b0;
      act_port_q <= '0;
      err_q <= 1'b0;
      err_rule_q <= '0;
      locked_q <= 1'b0;
      qreq_q <= 1'b0;
      gen_q <= '0;
      k_q <= '0;
    end else begin
      if (wr_ok && is_rule) sh_q[ri][boff +: 32] <= (rule_rd & ~wmask) | (reg_bus.wdata & wmask);
      if (wr_ok && is_dflt && reg_bus.wstrb[0]) sh_en_q <= reg_bus.wdata[0];
      if (wr_ok && is_dflt && reg_bus.wstrb[1]) sh_port_q <= reg_bus.wdata[15:8];
      if (wr_ok && is_ctrl && reg_bus.wstrb[0] && reg_bus.wdata[1]) locked_q <= 1'b1;
      case (state_q)
        IDLE: if (wr_ok && is_ctrl && reg_bus.wstrb[0] && reg_bus.wdata[0]) begin
          state_q <= CHECK;
          err_q <= 1'b0;
          k_q <= '0;
        end
        CHECK: if (rule_bad || (last && dflt_bad)) begin
          err_q <= 1'b1;
          err_rule_q <= rule_bad ? 6'(k_q) : 6'd63;
          state_q <= IDLE;
        end else if (last) begin
          state_q <= QUIESCE;
          qreq_q <= 1'b1;
        end else k_q <= k_q + 1'b1;
        QUIESCE: if (quiesce_ack_i) state_q <= APPLY;
        APPLY: begin
          act_q <= sh_q;
          act_en_q <= sh_en_q;
          act_port_q <= sh_port_q;
          gen_q <= gen_q + 8'd1;
          qreq_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign addr_map_o = act_q;
  assign en_default_mst_port_o = act_en_q;
  assign default_mst_port_o = act_port_q[PortW-1:0];
  assign quiesce_req_o = qreq_q;
  assign map_gen_o = gen_q;
  assign unused_ok = ^{reg_bus.addr[63:12], act_port_q[7:PortW]};
endmodule
